palette_mapper: RTL

Parametrised, programmable colour-lookup stage that replaces fixed hard-wired palettes in the VGA pixel path. It takes the 16-bit word read from SRAM, selects one byte as a colour index, looks the index up in one of `NUM_PAL` run-time-writable palettes, and drives registered `Red`/`Green`/`Blue` two cycles later. It sits between the SRAM tristate read path and the VGA DAC outputs. Optional blanking and brightness fade are applied at the output stage.

---
 rtl/palette_mapper.sv | 110 +++++++++++
 1 files changed

// File: rtl/palette_mapper.sv
// Two-stage programmable colour lookup: byte select + range check, then palette
// read with write-first bypass, blanking and per-channel fade shift.
module palette_mapper #(
  parameter int IDX_W   = 5,
  parameter int NUM_PAL = 2,
  parameter int COLOR_W = 8,
  localparam int PAL_W  = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
  localparam int DEPTH  = 2 ** IDX_W,
  localparam int RGB_W  = 3 * COLOR_W
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               pix_valid,
  input  logic [15:0]        sram_data,
  input  logic               ublb,
  input  logic [PAL_W-1:0]   pal_sel,
  input  logic               blank,
  input  logic [2:0]         fade,
  input  logic               wr_en,
  input  logic [PAL_W-1:0]   wr_pal,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [RGB_W-1:0]   wr_rgb,
  output logic [COLOR_W-1:0] Red,
  output logic [COLOR_W-1:0] Green,
  output logic [COLOR_W-1:0] Blue,
  output logic               pix_valid_out,
  output logic               oob
);

  logic [RGB_W-1:0]   mem_q [NUM_PAL][DEPTH];

  logic [7:0]         idx_q, idx_d;
  logic [PAL_W-1:0]   pal_q;
  logic               blank_q, vld_q, err_q, err_d;
  logic [2:0]         fade_q;

  logic [COLOR_W-1:0] chan_q [3];
  logic [COLOR_W-1:0] chan_d [3];
  logic               pv_q, oob_q;

  logic               wr_ok, hit, blk;
  logic [IDX_W-1:0]   rd_idx;
  logic [PAL_W-1:0]   rd_pal;
  logic [RGB_W-1:0]   entry;

  assign idx_d = ublb ? sram_data[7:0] : sram_data[15:8];
  assign err_d = (int'(idx_d) >= DEPTH) || (int'(pal_sel) >= NUM_PAL);
  assign wr_ok = wr_en && (int'(wr_pal) < NUM_PAL);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int e = 0; e < DEPTH; e++)
          mem_q[p][e] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_pal][wr_idx] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx_q   <= '0;
      pal_q   <= '0;
      blank_q <= 1'b0;
      fade_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      pal_q   <= pal_sel;
      blank_q <= blank;
      fade_q  <= fade;
      vld_q   <= pix_valid;
      err_q   <= err_d;
    end
  end

  // Out-of-range palettes read a harmless in-range slot; the result is masked by err_q.
  assign rd_idx = idx_q[IDX_W-1:0];
  assign rd_pal = (int'(pal_q) < NUM_PAL) ? pal_q : '0;
  assign hit    = wr_ok && (wr_pal == pal_q) && (wr_idx == rd_idx);
  assign entry  = hit ? wr_rgb : mem_q[rd_pal][rd_idx];
  assign blk    = err_q || blank_q;

  // Channel 2 is red, 1 green, 0 blue, matching the {R,G,B} packing.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign chan_d[gi] = blk ? '0 : (entry[gi*COLOR_W +: COLOR_W] >> fade_q);
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int c = 0; c < 3; c++) chan_q[c] <= '0;
      pv_q  <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) chan_q[c] <= chan_d[c];
      pv_q  <= vld_q;
      oob_q <= err_q & vld_q;
    end
  end

  assign Red           = chan_q[2];
  assign Green         = chan_q[1];
  assign Blue          = chan_q[0];
  assign pix_valid_out = pv_q;
  assign oob           = oob_q;

endmodule
